// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CiM SRAM port arbiter.
//   mem_src_t   : requester identity, index doubles as priority (0 = highest)
//   arb_state_t : arbiter mode (free arbitration or burst lock)
//   NUM_MEM_SRC : number of requesters sharing one bank
package mem_port_arbiter_pkg;

  localparam int unsigned NUM_MEM_SRC = 3;

  typedef enum logic [1:0] {
    BUS_FSM   = 2'd0,
    LOGIC_FSM = 2'd1,
    MAC       = 2'd2
  } mem_src_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Read-return tag pipeline: delays {valid, src} of each issued read by RD_LAT
// cycles so the read data arriving from the SRAM is steered to its issuer.
//   clk, rst_n : clock, asynchronous active-low clear (flushes in-flight tags)
//   in_valid   : a read command is on the SRAM port this cycle
//   in_src     : source that issued that read
//   rd_valid   : one-hot per-source flag aligned with the SRAM read data
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_MEM_SRC,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  mem_src_t           in_src,
  output logic [NUM_SRC-1:0] rd_valid
);

  logic [RD_LAT-1:0]      vld;
  logic [RD_LAT-1:0][1:0] src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      src <= '0;
    end else begin
      vld[0] <= in_valid;
      src[0] <= in_src;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        src[i] <= src[i-1];
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (vld[RD_LAT-1] && (src[RD_LAT-1] == i[1:0])) rd_valid[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port CiM SRAM bank between the bus FSM, the
// compute-control FSM and the MAC. Fixed priority (lower index wins), with a
// starvation override and an optional burst lock; one access per cycle.
//   req_valid/write/lock/addr/wdata : per-source request, held until req_ready
//   req_ready  : one-hot grant (combinational)
//   rd_valid   : per-source read-return strobe, rd_data shared
//   mem_*      : registered SRAM command; mem_rdata returns RD_LAT later
//   lock_owner : burst owner, meaningful while locked
//   locked     : arbiter is in burst-lock mode
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC      = NUM_MEM_SRC,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             req_valid,
  input  logic [NUM_SRC-1:0]             req_write,
  input  logic [NUM_SRC-1:0]             req_lock,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_SRC-1:0]             req_ready,
  output logic [NUM_SRC-1:0]             rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [1:0]                     lock_owner,
  output logic                           locked
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t               state, state_nxt;
  mem_src_t                 owner, owner_nxt;
  logic [NUM_SRC-1:0][3:0]  starve_cnt;
  logic [NUM_SRC-1:0]       starving;
  logic                     grant_any;
  logic                     starve_hit;
  mem_src_t                 grant_src;
  logic                     cmd_rd;
  mem_src_t                 cmd_src;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_FREE;
      owner <= BUS_FSM;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    starving = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      starving[i] = req_valid[i] && (starve_cnt[i] == STARVE_MAX);
    end
  end

  // Grant selection: a starving source beats both the lock and fixed priority
  always_comb begin
    starve_hit = 1'b0;
    grant_any  = 1'b0;
    grant_src  = BUS_FSM;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!starve_hit && starving[i]) begin
        starve_hit = 1'b1;
        grant_any  = 1'b1;
        grant_src  = mem_src_t'(i[1:0]);
      end
    end
    if (!starve_hit) begin
      if (state == ARB_LOCKED) begin
        grant_any = req_valid[owner];
        grant_src = owner;
      end else begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (!grant_any && req_valid[i]) begin
            grant_any = 1'b1;
            grant_src = mem_src_t'(i[1:0]);
          end
        end
      end
    end
    req_ready = '0;
    if (grant_any && rst_n) req_ready[grant_src] = 1'b1;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      ARB_FREE: begin
        if (grant_any && !starve_hit && req_lock[grant_src]) begin
          state_nxt = ARB_LOCKED;
          owner_nxt = grant_src;
        end
      end
      ARB_LOCKED: begin
        if (starve_hit || !req_valid[owner] || !req_lock[owner]) state_nxt = ARB_FREE;
      end
      default: state_nxt = ARB_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          if (starve_cnt[i] != 4'hF) starve_cnt[i] <= starve_cnt[i] + 4'd1;
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered SRAM command; address and data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_rd    <= 1'b0;
      cmd_src   <= BUS_FSM;
    end else begin
      mem_en  <= grant_any;
      mem_we  <= grant_any && req_write[grant_src];
      cmd_rd  <= grant_any && !req_write[grant_src];
      cmd_src <= grant_src;
      if (grant_any) begin
        mem_addr  <= req_addr[grant_src];
        mem_wdata <= req_wdata[grant_src];
      end
    end
  end

  rd_tag_pipe #(
    .NUM_SRC (NUM_SRC),
    .RD_LAT  (RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (cmd_rd),
    .in_src   (cmd_src),
    .rd_valid (rd_valid)
  );

  assign rd_data    = mem_rdata;
  assign lock_owner = owner;
  assign locked     = (state == ARB_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned NS           = 3;
  localparam int unsigned AW           = 11;
  localparam int unsigned DW           = 16;
  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam logic [AW-1:0] BASE       = 11'h100;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NS-1:0]          req_valid, req_write, req_lock, req_ready, rd_valid;
  logic [NS-1:0][AW-1:0]  req_addr;
  logic [NS-1:0][DW-1:0]  req_wdata;
  logic [DW-1:0]          rd_data, mem_wdata, mem_rdata;
  logic                   mem_en, mem_we, locked;
  logic [AW-1:0]          mem_addr;
  logic [1:0]             lock_owner;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_owner(lock_owner), .locked(locked)
  );

  // Behavioural SRAM: command on mem_* in cycle C, read data valid in C+RD_LAT
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 16'(a) * 16'd37 + 16'h01F3;
  endfunction

  logic [DW-1:0] sram  [0:2047];
  logic [DW-1:0] rpipe [0:RD_LAT-1];
  logic          sram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 2048; i++) sram[i] <= init_word(11'(i));
      sram_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
    if (mem_en) rpipe[0] <= sram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  // Stimulus helpers (drive only)
  task automatic drive_idle();
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drive_req(input int s, input logic w, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[s] = 1'b1; req_write[s] = w; req_lock[s] = lk;
    req_addr[s]  = a;    req_wdata[s] = d;
  endtask

  task automatic drop_req(input int s);
    req_valid[s] = 1'b0; req_write[s] = 1'b0; req_lock[s] = 1'b0;
  endtask

  logic [31:0] outs [8];
  string       out_nm [8] = '{"ready", "rd_valid", "mem_en", "mem_we",
                              "mem_addr", "mem_wdata", "locked", "lock_owner"};

  task automatic snap_outputs();
    outs = '{32'(req_ready), 32'(rd_valid), 32'(mem_en), 32'(mem_we),
             32'(mem_addr), 32'(mem_wdata), 32'(locked), 32'(lock_owner)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    snap_outputs();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (outs[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_%s: got %h expected 0", out_nm[i], outs[i]);
      end
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 11'h005, 16'h1234);
    drive_req(2, 1'b0, 1'b0, 11'h005, 16'h0000);
    #1; vectors++;
    if (req_ready !== 3'b001) begin miscompares++;
      $display("FAIL prio_grant0: got %b expected 001", req_ready); end
    @(negedge clk);
    drop_req(0);
    #1; vectors++;
    if (req_ready !== 3'b100) begin miscompares++;
      $display("FAIL prio_grant2: got %b expected 100", req_ready); end
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 11'h005, 16'h1234}) begin
      miscompares++;
      $display("FAIL prio_wr_cmd: got en=%b we=%b a=%h d=%h expected 1 1 005 1234",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    // src2 granted at offset 1: data returns at offset 2+RD_LAT
    for (int off = 2; off <= int'(RD_LAT) + 3; off++) begin
      @(negedge clk);
      if (off == 2) drop_req(2);
      #1;
      if (off == 2) begin
        vectors++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 11'h005}) begin miscompares++;
          $display("FAIL prio_rd_cmd: got en=%b we=%b a=%h expected 1 0 005",
                   mem_en, mem_we, mem_addr); end
      end
      vectors++;
      if (rd_valid !== ((off == int'(RD_LAT) + 2) ? 3'b100 : 3'b000)) begin miscompares++;
        $display("FAIL prio_rd_valid off%0d: got %b", off, rd_valid); end
      if (off == int'(RD_LAT) + 2) begin
        vectors++;
        if (rd_data !== 16'h1234) begin miscompares++;
          $display("FAIL prio_rd_data: got %h expected 1234", rd_data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 11'h001, '0);
    #1; vectors++;
    if (req_ready !== 3'b010) begin miscompares++;
      $display("FAIL b2b_grant1: got %b expected 010", req_ready); end
    @(negedge clk);
    drop_req(1);
    drive_req(2, 1'b0, 1'b0, 11'h002, '0);
    #1; vectors++;
    if (req_ready !== 3'b100) begin miscompares++;
      $display("FAIL b2b_grant2: got %b expected 100", req_ready); end
    for (int off = 2; off <= int'(RD_LAT) + 3; off++) begin
      logic [NS-1:0] ev;
      logic [DW-1:0] ed;
      @(negedge clk);
      if (off == 2) drop_req(2);
      ev = '0; ed = '0;
      if (off == int'(RD_LAT) + 1) begin ev = 3'b010; ed = init_word(11'h001); end
      if (off == int'(RD_LAT) + 2) begin ev = 3'b100; ed = init_word(11'h002); end
      #1; vectors++;
      if (rd_valid !== ev) begin miscompares++;
        $display("FAIL b2b_rd_valid off%0d: got %b expected %b", off, rd_valid, ev); end
      if (ev != '0) begin
        vectors++;
        if (rd_data !== ed) begin miscompares++;
          $display("FAIL b2b_rd_data off%0d: got %h expected %h", off, rd_data, ed); end
      end
    end
  endtask

  task automatic test_burst_lock();
    for (int k = 0; k <= 6; k++) begin
      logic [NS-1:0] er;
      logic          el;
      @(negedge clk);
      if (k <= 5) drive_req(2, 1'b0, k < 4, 11'h020 + 11'(k), '0);
      if (k >= 1 && k <= 5) drive_req(1, 1'b0, 1'b0, 11'h030, '0);
      if (k == 6) drop_req(1);
      er = (k == 5) ? 3'b010 : 3'b100;
      el = (k >= 1 && k <= 4);
      #1; vectors++;
      if (req_ready !== er || locked !== el) begin miscompares++;
        $display("FAIL burst_k%0d: got ready=%b locked=%b expected %b %b",
                 k, req_ready, locked, er, el); end
      if (el) begin
        vectors++;
        if (lock_owner !== 2'd2) begin miscompares++;
          $display("FAIL burst_owner_k%0d: got %0d expected 2", k, lock_owner); end
      end
    end
    @(negedge clk);
    drive_idle();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_starvation();
    for (int c = 1; c <= 18; c++) begin
      logic [NS-1:0] er;
      @(negedge clk);
      drive_req(0, 1'b0, 1'b0, 11'h040, '0);
      drive_req(2, 1'b0, 1'b0, 11'h041, '0);
      er = (c == int'(STARVE_LIMIT) + 1 || c == 2 * int'(STARVE_LIMIT) + 2) ? 3'b100 : 3'b001;
      #1; vectors++;
      if (req_ready !== er) begin miscompares++;
        $display("FAIL starve_c%0d: got %b expected %b", c, req_ready, er); end
    end
    @(negedge clk);
    drive_idle();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_lock_break();
    for (int c = 0; c <= 12; c++) begin
      logic [NS-1:0] er;
      logic          el;
      @(negedge clk);
      if (c <= 10) drive_req(2, 1'b0, 1'b1, 11'h050, '0); else drop_req(2);
      if (c >= 1 && c <= 9) drive_req(1, 1'b0, 1'b0, 11'h060, '0); else drop_req(1);
      er = (c == 9) ? 3'b010 : (c <= 10) ? 3'b100 : 3'b000;
      el = (c >= 1 && c <= 9) || c == 11;
      #1; vectors++;
      if (req_ready !== er || locked !== el) begin miscompares++;
        $display("FAIL lockbrk_c%0d: got ready=%b locked=%b expected %b %b",
                 c, req_ready, locked, er, el); end
    end
    drive_idle();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    drive_req(2, 1'b0, 1'b1, 11'h010, '0);
    #1; vectors++;
    if (req_ready !== 3'b100) begin miscompares++;
      $display("FAIL rstmid_grant: got %b expected 100", req_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    snap_outputs();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (outs[i] !== 32'd0) begin miscompares++;
        $display("FAIL rstmid_%s: got %h expected 0", out_nm[i], outs[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(RD_LAT) + 3; k++) begin
      @(negedge clk);
      #1; vectors++;
      if (rd_valid !== 3'b000) begin miscompares++;
        $display("FAIL rstmid_no_rd k%0d: got %b expected 000", k, rd_valid); end
    end
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 11'h011, '0);
    drive_req(2, 1'b0, 1'b1, 11'h012, '0);
    #1; vectors++;
    if (req_ready !== 3'b010 || locked !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_free: got ready=%b locked=%b expected 010 0", req_ready, locked); end
    @(negedge clk);
    drive_idle();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  // Reference model for the random test, driven from the pending-request view
  typedef struct { int due; int src; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [NS-1:0] p_valid, p_write, p_lock;
  logic [AW-1:0] p_addr [NS];
  logic [DW-1:0] p_data [NS];
  logic [DW-1:0] shadow [16];
  int            m_wait [NS];
  bit            m_locked;
  int            m_owner, mcyc;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  function automatic int starving_src();
    for (int i = 0; i < int'(NS); i++)
      if (p_valid[i] && m_wait[i] == int'(STARVE_LIMIT)) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] model_ready();
    int s = starving_src();
    if (s >= 0) return 3'b001 << s;
    if (m_locked) return p_valid[m_owner] ? (3'b001 << m_owner) : 3'b000;
    for (int i = 0; i < int'(NS); i++) if (p_valid[i]) return 3'b001 << i;
    return 3'b000;
  endfunction

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < int'(NS); i++) m_wait[i] = 0;
    for (int i = 0; i < 16; i++) shadow[i] = init_word(BASE + 11'(i));
    m_locked = 0; m_owner = 0; mcyc = 0;
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    p_valid = '0; p_write = '0; p_lock = '0;
  endtask

  task automatic model_advance(input logic [NS-1:0] g);
    int  gs = -1;
    bit  starve = (starving_src() >= 0);
    for (int i = 0; i < int'(NS); i++) if (g[i]) gs = i;
    if (starve) m_locked = 0;
    else if (m_locked) begin
      if (!p_valid[m_owner] || !p_lock[m_owner]) m_locked = 0;
    end else if (gs >= 0 && p_lock[gs]) begin
      m_locked = 1; m_owner = gs;
    end
    for (int i = 0; i < int'(NS); i++)
      m_wait[i] = (p_valid[i] && !g[i]) ? ((m_wait[i] < 15) ? m_wait[i] + 1 : 15) : 0;
    mcyc++;
    m_en = (gs >= 0);
    if (gs >= 0) begin
      m_we = p_write[gs]; m_addr = p_addr[gs]; m_wdata = p_data[gs];
      if (p_write[gs]) shadow[p_addr[gs] - BASE] = p_data[gs];
      else rq.push_back('{due: mcyc + int'(RD_LAT), src: gs, data: shadow[p_addr[gs] - BASE]});
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [NS-1:0] er, ev;
      logic [DW-1:0] ed;
      @(negedge clk);
      for (int s = 0; s < int'(NS); s++) begin
        if (!p_valid[s] && $urandom_range(0, 99) < 60) begin
          p_valid[s] = 1'b1;
          p_write[s] = $urandom_range(0, 1) == 1;
          p_lock[s]  = $urandom_range(0, 99) < 30;
          p_addr[s]  = BASE + 11'($urandom_range(0, 15));
          p_data[s]  = 16'($urandom);
        end
        req_valid[s] = p_valid[s];
        req_write[s] = p_valid[s] & p_write[s];
        req_lock[s]  = p_valid[s] & p_lock[s];
        req_addr[s]  = p_addr[s];
        req_wdata[s] = p_data[s];
      end
      er = model_ready();
      ev = '0; ed = '0;
      if (rq.size() > 0 && rq[0].due == mcyc) begin
        ev[rq[0].src] = 1'b1; ed = rq[0].data; void'(rq.pop_front());
      end
      #1;
      vectors++;
      if (req_ready !== er) begin miscompares++;
        $display("FAIL rnd_ready cyc%0d: got %b expected %b", cyc, req_ready, er); end
      vectors++;
      if (rd_valid !== ev) begin miscompares++;
        $display("FAIL rnd_rd_valid cyc%0d: got %b expected %b", cyc, rd_valid, ev); end
      if (ev != '0) begin
        vectors++;
        if (rd_data !== ed) begin miscompares++;
          $display("FAIL rnd_rd_data cyc%0d: got %h expected %h", cyc, rd_data, ed); end
      end
      vectors++;
      if (mem_en !== m_en || mem_addr !== m_addr || mem_wdata !== m_wdata) begin miscompares++;
        $display("FAIL rnd_mem cyc%0d: got en=%b a=%h d=%h expected %b %h %h",
                 cyc, mem_en, mem_addr, mem_wdata, m_en, m_addr, m_wdata); end
      if (m_en) begin
        vectors++;
        if (mem_we !== m_we) begin miscompares++;
          $display("FAIL rnd_we cyc%0d: got %b expected %b", cyc, mem_we, m_we); end
      end
      vectors++;
      if (locked !== m_locked) begin miscompares++;
        $display("FAIL rnd_locked cyc%0d: got %b expected %b", cyc, locked, m_locked); end
      if (m_locked) begin
        vectors++;
        if (lock_owner !== 2'(m_owner)) begin miscompares++;
          $display("FAIL rnd_owner cyc%0d: got %0d expected %0d", cyc, lock_owner, m_owner); end
      end
      model_advance(er);
      p_valid = p_valid & ~er;
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_fixed_priority();
    test_back_to_back();
    test_burst_lock();
    test_starvation();
    test_lock_break();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
